// File: rtl/systolic_skew_feeder.sv
// Operand buffer and diagonal-skew edge feeder for an NxN systolic MAC array.
// Optional sticky protocol-error flag is built when FEEDER_PROTO_ERR_EN is defined.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 8,
    localparam int IW = $clog2((N > K) ? N : K)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [IW-1:0]   wr_row,
    input  logic [IW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic [N*DW-1:0] left_data,
    output logic [N*DW-1:0] up_data,
    output logic            array_clr,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int CW = $clog2(K + 2 * N);
    localparam logic [CW-1:0] STREAM_LAST = CW'(K + N - 2);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(K + 2 * N - 3);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [N*DW-1:0] left_next, up_next;
    logic            clr_next, busy_next, done_next, err_next;

    logic [DW-1:0] a_buf [N][K];
    logic [DW-1:0] b_buf [K][N];

    // Buffers carry no reset; decoding each cell drops out-of-range indices.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < K; c++)
                    if (!wr_sel && wr_row == IW'(r) && wr_col == IW'(c))
                        a_buf[r][c] <= wr_data;
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < N; c++)
                    if (wr_sel && wr_row == IW'(r) && wr_col == IW'(c))
                        b_buf[r][c] <= wr_data;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE:   if (start) state_next = CLEAR;
            CLEAR: begin
                state_next = STREAM;
                cnt_next   = '0;
            end
            STREAM: begin
                cnt_next = cnt + 1'b1;
                if (cnt == STREAM_LAST) state_next = DRAIN;
            end
            DRAIN: begin
                cnt_next = cnt + 1'b1;
                if (cnt == DRAIN_LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are precomputed from the upcoming state so they register cleanly.
        clr_next  = (state_next == CLEAR);
        busy_next = (state_next == CLEAR) || (state_next == STREAM) || (state_next == DRAIN);
        done_next = (state_next == DONE);

        left_next = '0;
        up_next   = '0;
        if (state_next == STREAM) begin
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned k = 0; k < K; k++)
                    if (cnt_next == CW'(i + k)) begin
                        left_next[i*DW +: DW] = a_buf[i][k];
                        up_next[i*DW +: DW]   = b_buf[k][i];
                    end
        end

`ifdef FEEDER_PROTO_ERR_EN
        err_next = err;
        if (busy && (start || wr_en)) err_next = 1'b1;
        if (wr_en && (wr_sel ? (int'(wr_row) >= K || int'(wr_col) >= N)
                             : (int'(wr_row) >= N || int'(wr_col) >= K)))
            err_next = 1'b1;
`else
        err_next = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            left_data <= '0;
            up_data   <= '0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            left_data <= left_next;
            up_data   <= up_next;
            array_clr <= clr_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
        end
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream feeder for the N×N systolic MAC array. It buffers operand matrices A (N×K) and B (K×N), which the host writes element by element. On start it pulses an array clear, then streams A rows into the left edge and B columns into the top edge with diagonal skew, so PE[i][j] accumulates C[i][j] = sum over k of A[i][k]*B[k][j]. It then waits for the wavefront to drain and signals done.

Parameters:
N, 4, array dimension (rows of A = cols of B = PEs per side); N >= 2
K, 4, inner dimension (cols of A = rows of B); K >= 1
DW, 8, signed operand width; matches PE up_in/left_in

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write one operand element this cycle
wr_sel  input  1  0 = A buffer, 1 = B buffer
wr_row  input  clog2(max(N,K))  row index (A: 0..N-1, B: 0..K-1)
wr_col  input  clog2(max(N,K))  col index (A: 0..K-1, B: 0..N-1)
wr_data  input  DW  signed element
start  input  1  single-cycle request to run one multiply
left_data  output  N*DW  row i edge value at bits [i*DW +: DW], to PE[i][0].left_in
up_data  output  N*DW  col j edge value at bits [j*DW +: DW], to PE[0][j].up_in
array_clr  output  1  one-cycle clear to the array accumulators (OR'd into PE reset)
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when all PE mat_out values are final
err  output  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Reset values: left_data=0, up_data=0, array_clr=0, busy=0, done=0, err=0, state=IDLE. Buffer contents are undefined after reset and are not cleared.
- Buffers: writes are accepted only in IDLE. Out-of-range indices are dropped. A write and a start in the same IDLE cycle are both honoured, and the written value is used in the run.
- FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE. All outputs are registered.
- IDLE: a start sampled high moves the FSM to CLEAR. busy rises in the CLEAR cycle.
- CLEAR (1 cycle): array_clr=1. Edge data = 0.
- STREAM (K+N-1 cycles, feed cycle t = 0..K+N-2):
  - left_data row i = A[i][t-i] when 0 <= t-i < K, else 0.
  - up_data col j = B[t-j][j] when 0 <= t-j < K, else 0.
  - Values are visible during cycle t and sampled by the array at the edge ending cycle t.
- DRAIN (N-1 cycles, t = K+N-1 .. K+2N-3): edge data = 0. Cycle counter continues.
- DONE (t = K+2N-2): done=1 for 1 cycle, busy=0 in the same cycle, edge data = 0. Then IDLE.
- Total latency: start edge to done = K+2N cycles.
- start while busy is ignored. wr_en while busy is ignored, and buffers are unchanged.
- Reset mid-run: immediate return to IDLE, all outputs zeroed. No done pulse.
- Data pass through unmodified. No arithmetic is performed. The sign of operands is preserved bit-exact.

Optional Feature:
- Macro: FEEDER_PROTO_ERR_EN.
- Defined: err sets on any of the following:
  - start while busy;
  - wr_en while busy;
  - wr_en with an out-of-range index.
  - err is sticky until reset.
- Undefined: err is tied 0 and the violations are silently ignored as above.

Test Plan:
- N=2,K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start:
  - array_clr 1 cycle;
  - left row0 = 1,2,0 / row1 = 0,3,4;
  - up col0 = 5,7,0 / col1 = 0,6,8;
  - done at t=4;
  - array C = [[19,22],[43,50]].
- Signed extremes, A all -128 and B all -128 with N=2,K=2 -> edge bytes 0x80 bit-exact; PE accumulators = 32768.
- start asserted during STREAM -> ignored; exactly one done pulse, K+2N cycles after the original start; err=1 only with FEEDER_PROTO_ERR_EN.
- wr_en to A[0][0]=9 during busy -> next run still streams the old value; with macro, err=1.
- reset asserted at t=1 of STREAM -> all outputs 0 immediately, busy=0, no done; a new start then runs normally.
- wr_en (A[0][0]=7) and start in the same IDLE cycle -> row0 t0 shows 7.
